dram_serial_responder: RTL and testbench

DRAM_SERIAL_RESPONDER -- requirements
Module: dram_serial_responder

---
 rtl/dram_serial_responder_pkg.sv | 19 +
 rtl/dram_core_lane.sv | 61 ++++++
 rtl/dram_serial_responder.sv | 179 +++++++++++++++++
 tb/tb_dram_serial_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_serial_responder_pkg.sv
// Shared sizing constants and read-sequencer state encoding for the serial DRAM responder.
package dram_serial_responder_pkg;

  localparam int N_CORE_DEF = 16;
  localparam int N_ROW_DEF  = 64;
  localparam int ROW_W_DEF  = 64;

  localparam int ADDR_BITS  = 9;
  localparam int DEMUX_W    = 3;
  localparam int BYTE_W     = 8;
  localparam int ROW_AW     = ADDR_BITS - DEMUX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SENSE = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/dram_core_lane.sv
// One DRAM core: serial write shifter, row storage, byte select and serial read shifter.
module dram_core_lane
  import dram_serial_responder_pkg::*;
#(
  parameter int N_ROW = N_ROW_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_in,
  input  logic               d_shift,
  input  logic               wr_en,
  input  logic [ROW_AW-1:0]  wr_row,
  input  logic [ROW_AW-1:0]  rd_row,
  input  logic [DEMUX_W-1:0] rd_demux,
  input  logic               load_en,
  input  logic               shift_en,
  input  logic               rout_vld,
  output logic               rout
);

  localparam int BIT_AW = $clog2(ROW_W);

  logic [ROW_W-1:0]  wsr;
  logic [ROW_W-1:0]  mem [N_ROW];
  logic [ROW_W-1:0]  rd_word;
  logic [BIT_AW-1:0] byte_msb;
  logic [BYTE_W-1:0] rsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsr <= '0;
    end else if (d_shift) begin
      wsr <= {wsr[ROW_W-2:0], d_in};
    end
  end

  // Storage is deliberately left out of reset so contents survive RST.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wsr;
    end
  end

  // demux 0 picks bits 63:56, demux 7 picks bits 7:0.
  assign rd_word  = mem[rd_row];
  assign byte_msb = {~rd_demux, 3'b111};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsr <= '0;
    end else if (load_en) begin
      rsr <= rd_word[byte_msb -: BYTE_W];
    end else if (shift_en) begin
      rsr <= {rsr[BYTE_W-2:0], 1'b0};
    end
  end

  assign rout = rout_vld & rsr[BYTE_W-1];

endmodule

// File: rtl/dram_serial_responder.sv
// Serial-address/serial-data DRAM responder: N_CORE lanes sharing one address, write and read sequencer.
//   state    | meaning
//   ST_IDLE  | no read in progress, accepts RD_EN
//   ST_SENSE | lanes load the addressed byte (1 cycle)
//   ST_SHIFT | lanes shift the byte out MSB first (8 cycles)
module dram_serial_responder
  import dram_serial_responder_pkg::*;
#(
  parameter int N_CORE = N_CORE_DEF,
  parameter int N_ROW  = N_ROW_DEF,
  parameter int ROW_W  = ROW_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ADD_IN,
  input  logic              ADD_VALID_IN,
  input  logic [N_CORE-1:0] D_IN,
  input  logic              DATA_VALID_IN,
  input  logic              WRI_EN,
  input  logic              RD_EN,
  output logic [N_CORE-1:0] ROUT,
  output logic              ROUT_VLD,
  output logic              BUSY,
  output logic              ERR
);

  localparam int               DCW       = $clog2(ROW_W + 1);
  localparam logic [DCW-1:0]   DATA_FULL = DCW'(ROW_W);
  localparam logic [3:0]       ADDR_FULL = 4'(ADDR_BITS);
  localparam int               SCW       = $clog2(BYTE_W);

  state_t state, state_nxt;
  logic [SCW-1:0] shift_cnt, shift_cnt_nxt;
  logic load_en, shift_en;

  logic [ADDR_BITS-1:0] addr_sr;
  logic [3:0]           addr_cnt;
  logic                 add_valid_q;
  logic                 addr_ok;
  logic                 addr_fall;
  logic [ROW_AW-1:0]    row_q, rd_row;
  logic [DEMUX_W-1:0]   demux_q, rd_demux;

  logic [DCW-1:0] data_cnt;
  logic           data_valid_q;
  logic           data_full;

  logic wr_go, rd_go, err_set;

  assign addr_fall = add_valid_q & ~ADD_VALID_IN;
  assign data_full = (data_cnt == DATA_FULL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_sr     <= '0;
      addr_cnt    <= '0;
      add_valid_q <= 1'b0;
      addr_ok     <= 1'b0;
      row_q       <= '0;
      demux_q     <= '0;
    end else begin
      add_valid_q <= ADD_VALID_IN;
      if (ADD_VALID_IN) begin
        addr_sr <= {addr_sr[ADDR_BITS-2:0], ADD_IN};
        if (!add_valid_q)
          addr_cnt <= 4'd1;
        else if (addr_cnt != ADDR_FULL)
          addr_cnt <= addr_cnt + 4'd1;
      end
      if (addr_fall) begin
        if (addr_cnt == ADDR_FULL) begin
          row_q   <= addr_sr[ADDR_BITS-1 -: ROW_AW];
          demux_q <= addr_sr[DEMUX_W-1:0];
          addr_ok <= 1'b1;
        end else begin
          addr_ok <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_cnt     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= DATA_VALID_IN;
      if (DATA_VALID_IN) begin
        if (!data_valid_q)
          data_cnt <= DCW'(1);
        else if (!data_full)
          data_cnt <= data_cnt + DCW'(1);
      end
    end
  end

  // A simultaneous WRI_EN+RD_EN cancels both.
  assign wr_go   = WRI_EN & addr_ok & data_full & ~RD_EN;
  assign rd_go   = RD_EN & addr_ok & (state == ST_IDLE) & ~WRI_EN;
  assign err_set = (addr_fall & (addr_cnt != ADDR_FULL)) | (WRI_EN & ~wr_go) | (RD_EN & ~rd_go);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (err_set) begin
      ERR <= 1'b1;
    end
  end

  // The read keeps its own copy of the address so later address frames cannot disturb it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_row   <= '0;
      rd_demux <= '0;
    end else if (rd_go) begin
      rd_row   <= row_q;
      rd_demux <= demux_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      shift_cnt <= '0;
    end else begin
      state     <= state_nxt;
      shift_cnt <= shift_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_cnt_nxt = shift_cnt;
    load_en       = 1'b0;
    shift_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_go) state_nxt = ST_SENSE;
      end
      ST_SENSE: begin
        load_en       = 1'b1;
        shift_cnt_nxt = SCW'(BYTE_W - 1);
        state_nxt     = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (shift_cnt == '0)
          state_nxt = ST_IDLE;
        else
          shift_cnt_nxt = shift_cnt - SCW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ROUT_VLD = (state == ST_SHIFT);
  assign BUSY     = (state != ST_IDLE);

  for (genvar c = 0; c < N_CORE; c++) begin : g_lane
    dram_core_lane #(
      .N_ROW (N_ROW),
      .ROW_W (ROW_W)
    ) u_lane (
      .clk      (CLK),
      .rst      (RST),
      .d_in     (D_IN[c]),
      .d_shift  (DATA_VALID_IN),
      .wr_en    (wr_go),
      .wr_row   (row_q),
      .rd_row   (rd_row),
      .rd_demux (rd_demux),
      .load_en  (load_en),
      .shift_en (shift_en),
      .rout_vld (ROUT_VLD),
      .rout     (ROUT[c])
    );
  end

endmodule

// File: tb/tb_dram_serial_responder.sv
// Directed bench for dram_serial_responder: vector table of reads plus error/reset sequences.
module tb_dram_serial_responder;

  localparam int NC = 16;

  typedef logic [NC-1:0][7:0]  bytes_t;
  typedef logic [NC-1:0][63:0] words_t;
  typedef struct {
    logic [5:0] row;
    logic [2:0] demux;
    bytes_t     exp;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ADD_IN = 1'b0;
  logic          ADD_VALID_IN = 1'b0;
  logic [NC-1:0] D_IN = '0;
  logic          DATA_VALID_IN = 1'b0;
  logic          WRI_EN = 1'b0;
  logic          RD_EN = 1'b0;
  logic [NC-1:0] ROUT;
  logic          ROUT_VLD;
  logic          BUSY;
  logic          ERR;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t       tbl [12];
  logic [7:0] r5b [8];
  words_t     w5, w0, w63, wones;
  bytes_t     e;

  dram_serial_responder dut (
    .CLK           (CLK),
    .RST           (RST),
    .ADD_IN        (ADD_IN),
    .ADD_VALID_IN  (ADD_VALID_IN),
    .D_IN          (D_IN),
    .DATA_VALID_IN (DATA_VALID_IN),
    .WRI_EN        (WRI_EN),
    .RD_EN         (RD_EN),
    .ROUT          (ROUT),
    .ROUT_VLD      (ROUT_VLD),
    .BUSY          (BUSY),
    .ERR           (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int tag, input int c, input int k);
    return 8'(c * 16 + k) ^ ((tag != 0) ? 8'hFF : 8'h00);
  endfunction

  function automatic logic [63:0] pat(input int tag, input int c);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = pbyte(tag, c, k);
    return w;
  endfunction

  task automatic send_addr(input logic [5:0] row, input logic [2:0] dm, input int nbits);
    logic [8:0] f;
    f = {row, dm};
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      ADD_VALID_IN = 1'b1;
      ADD_IN       = f[8-i];
    end
    @(negedge CLK);
    ADD_VALID_IN = 1'b0;
    ADD_IN       = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_data(input words_t w);
    for (int b = 63; b >= 0; b--) begin
      @(negedge CLK);
      DATA_VALID_IN = 1'b1;
      for (int c = 0; c < NC; c++) D_IN[c] = w[c][b];
    end
    @(negedge CLK);
    DATA_VALID_IN = 1'b0;
    D_IN          = '0;
  endtask

  task automatic pulse(input logic wr, input logic rd);
    @(negedge CLK);
    WRI_EN = wr;
    RD_EN  = rd;
    @(negedge CLK);
    WRI_EN = 1'b0;
    RD_EN  = 1'b0;
  endtask

  // Issues RD_EN and checks SENSE, the 8 SHIFT bits and the return to idle.
  // poke_bit >= 0 raises RD_EN for one cycle during that SHIFT bit.
  task automatic read_check(input bytes_t exp, input int poke_bit, input string name);
    logic [NC-1:0] eb;
    @(negedge CLK);
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    chk({name, " sense busy"}, BUSY, 1);
    chk({name, " sense vld"}, ROUT_VLD, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      RD_EN = 1'b0;
      for (int c = 0; c < NC; c++) eb[c] = exp[c][7-k];
      chk($sformatf("%s bit%0d vld", name, k), ROUT_VLD, 1);
      chk($sformatf("%s bit%0d rout", name, k), ROUT, eb);
      if (k == poke_bit) RD_EN = 1'b1;
    end
    @(negedge CLK);
    RD_EN = 1'b0;
    chk({name, " end vld"}, ROUT_VLD, 0);
    chk({name, " end busy"}, BUSY, 0);
    chk({name, " end rout"}, ROUT, 0);
  endtask

  task automatic no_read_check(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      seen = seen | ROUT_VLD | BUSY;
    end
    chk({name, " no read activity"}, seen, 0);
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    r5b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    for (int i = 0; i < 8; i++) begin
      tbl[i].row   = 6'd5;
      tbl[i].demux = 3'(i);
      tbl[i].exp   = '0;
      tbl[i].exp[1] = r5b[i];
    end
    tbl[8].row  = 6'd0;  tbl[8].demux  = 3'd0;
    tbl[9].row  = 6'd0;  tbl[9].demux  = 3'd5;
    tbl[10].row = 6'd63; tbl[10].demux = 3'd2;
    tbl[11].row = 6'd63; tbl[11].demux = 3'd7;
    for (int i = 8; i < 12; i++)
      for (int c = 0; c < NC; c++)
        tbl[i].exp[c] = pbyte((i >= 10) ? 1 : 0, c, int'(tbl[i].demux));

    w5 = '0;
    w5[1] = 64'h0123456789ABCDEF;
    wones = '1;
    for (int c = 0; c < NC; c++) begin
      w0[c]  = pat(0, c);
      w63[c] = pat(1, c);
    end

    repeat (3) @(negedge CLK);
    chk("reset rout", ROUT, 0);
    chk("reset vld", ROUT_VLD, 0);
    chk("reset busy", BUSY, 0);
    chk("reset err", ERR, 0);
    RST = 1'b0;

    send_addr(6'd5, 3'd0, 9);
    send_data(w5);
    pulse(1'b1, 1'b0);
    chk("write row5 err", ERR, 0);
    e = '0;
    e[1] = 8'h01;
    read_check(e, -1, "row5 demux0");

    send_addr(6'd0, 3'd3, 9);
    send_data(w0);
    pulse(1'b1, 1'b0);
    send_addr(6'd63, 3'd4, 9);
    send_data(w63);
    pulse(1'b1, 1'b0);
    chk("write rows 0/63 err", ERR, 0);

    for (int i = 0; i < 12; i++) begin
      send_addr(tbl[i].row, tbl[i].demux, 9);
      read_check(tbl[i].exp, -1, $sformatf("tbl%0d", i));
    end
    chk("table reads err", ERR, 0);

    // Short address frame
    send_addr(6'd5, 3'd7, 7);
    chk("short addr err", ERR, 1);
    pulse(1'b0, 1'b1);
    no_read_check("short addr read");
    chk("err sticky", ERR, 1);
    reset_pulse();
    chk("err cleared by reset", ERR, 0);

    // RD_EN during SHIFT, then WRI_EN+RD_EN together
    send_addr(6'd5, 3'd7, 9);
    e = '0;
    e[1] = 8'hEF;
    read_check(e, 2, "rd during shift");
    chk("rd during shift err", ERR, 1);
    reset_pulse();
    send_addr(6'd5, 3'd7, 9);
    send_data(wones);
    pulse(1'b1, 1'b1);
    chk("wr+rd err", ERR, 1);
    no_read_check("wr+rd");
    read_check(e, -1, "mem unchanged");

    // Reset in the middle of SHIFT
    reset_pulse();
    pulse(1'b1, 1'b0);
    chk("incomplete write err", ERR, 1);
    send_addr(6'd5, 3'd7, 9);
    @(negedge CLK);
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    repeat (5) @(negedge CLK);
    chk("pre-reset bit4 rout", ROUT, 16'h0002);
    RST = 1'b1;
    #1;
    chk("mid-shift reset rout", ROUT, 0);
    chk("mid-shift reset vld", ROUT_VLD, 0);
    chk("mid-shift reset busy", BUSY, 0);
    chk("mid-shift reset err", ERR, 0);
    #1;
    RST = 1'b0;
    send_addr(6'd5, 3'd3, 9);
    e = '0;
    e[1] = 8'h67;
    read_check(e, -1, "after reset read");
    chk("final err", ERR, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
